rename_regfile: RTL and testbench
=================================

Name: rename_regfile

Overview:
- Architectural register file plus rename-tag table; the receiving end of the reorder buffer's in-order commit port.
- Records which ROB entry will produce each register when an instruction is issued.
- Absorbs committed results, retiring a register's tag only when the committing entry is its latest producer.
- Serves two combinational source queries to the issue stage and clears all tags on a commit-time flush (mispredict or jump).

Parameters:
- ROB_LOG, 4, width of a ROB entry id (ROB holds 2^ROB_LOG entries).
- NREG, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global ready; low freezes all state updates
- flush  in  1  commit-time redirect from ROB; clears all rename tags
- commit_valid  in  1  ROB commit writes a register this cycle
- commit_index  in  5  destination register of the commit
- commit_rob_id  in  ROB_LOG  ROB id of the committing entry
- commit_value  in  32  result value
- issue_valid  in  1  issue stage allocates a destination register
- issue_dest  in  5  destination register of the issuing instruction
- issue_rob_id  in  ROB_LOG  ROB id allocated to the issuing instruction
- rs1_index  in  5  source-1 query
- rs2_index  in  5  source-2 query
- rs1_busy  out  1  source-1 pending in ROB
- rs1_rob_id  out  ROB_LOG  producing ROB id when busy, else 0
- rs1_value  out  32  register value when not busy, else 0
- rs2_busy, rs2_rob_id, rs2_value  out  same as rs1 for source 2

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- State per register: value[31:0], busy, tag[ROB_LOG-1:0].
- On rst: all value=0, busy=0, tag=0. rst has priority over every other input.
- With rdy=0 and rst=0, state holds. Query outputs remain combinational on the held state.
- Commit (posedge; rdy=1, commit_valid=1, commit_index!=0):
  - value[commit_index] <= commit_value unconditionally.
  - If busy && tag==commit_rob_id, busy <= 0.
  - If the tag does not match, busy and tag are untouched; a younger producer is still pending.
- Issue (posedge; rdy=1, issue_valid=1, issue_dest!=0, flush=0): busy[issue_dest] <= 1, tag[issue_dest] <= issue_rob_id.
- Issue and commit to the same register in one cycle: the value is written, and the issue wins on tags (busy=1, tag=issue_rob_id).
- Flush (rdy=1, flush=1):
  - All busy <= 0 in the same edge.
  - Values are kept; the commit accompanying the flush is applied first, so a jalr link value is retained.
  - Issue is ignored that cycle.
- x0: writes and issues ignored. Queries of x0 return busy=0, rob_id=0, value=0.
- Query (combinational, per source), in priority order:
  - index==0 -> (0, 0, 0).
  - Bypass: busy && commit_valid && rdy && commit_index==index && tag==commit_rob_id -> busy=0, value=commit_value, rob_id=0.
  - Otherwise busy -> busy=1, rob_id=tag, value=0.
  - Otherwise busy=0, value=value[index], rob_id=0.
- Same-cycle issue does not affect queries. Source reads see the mapping that existed before the issuing instruction's own rename, so rd==rs1 reads the old producer.
- Flush does not alter same-cycle query outputs; the issue stage discards its issue on flush.
- Latency: state updates are visible to queries the cycle after the edge. Commit data is visible in the same cycle via the bypass.

Test Plan:
- Reset, then query x5/x0 -> busy=0, value=0, rob_id=0 on both ports.
- Issue x5 with rob_id 3; next cycle query x5 -> busy=1, rob_id=3. Commit x5, id 3, value 0xDEADBEEF -> same-cycle query gives busy=0, value=0xDEADBEEF; next cycle the same.
- Issue x7 with id 2, then issue x7 with id 6; commit x7, id 2, value 11 -> x7 stays busy with rob_id=6. Commit id 6, value 22 -> busy=0, value=22.
- Same cycle: issue x9 with id 4 and commit x9, id 1, value 7 (x9 tag 1) -> after the edge busy=1, tag=4, stored value 7. Query x9 in that cycle with rs1=rd -> bypass gives value 7, busy=0.
- With x1..x31 all busy, assert flush with commit x1, id t, value 0x100 and issue x2 -> all busy=0, x1=0x100, x2 value unchanged.
- Issue/commit to x0 with value 99 -> x0 query stays 0 and not busy. With rdy=0, issue and commit pulses produce no state change.

Source files
------------

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags.
// Absorbs in-order ROB commits and serves two bypassed source queries.
module rename_regfile #(
    parameter int ROB_LOG = 4,
    parameter int NREG    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               flush,
    input  logic               commit_valid,
    input  logic [4:0]         commit_index,
    input  logic [ROB_LOG-1:0] commit_rob_id,
    input  logic [31:0]        commit_value,
    input  logic               issue_valid,
    input  logic [4:0]         issue_dest,
    input  logic [ROB_LOG-1:0] issue_rob_id,
    input  logic [4:0]         rs1_index,
    input  logic [4:0]         rs2_index,
    output logic               rs1_busy,
    output logic [ROB_LOG-1:0] rs1_rob_id,
    output logic [31:0]        rs1_value,
    output logic               rs2_busy,
    output logic [ROB_LOG-1:0] rs2_rob_id,
    output logic [31:0]        rs2_value
);

    logic [31:0]        value_q [NREG];
    logic [NREG-1:0]    busy_q;
    logic [ROB_LOG-1:0] tag_q   [NREG];

    logic commit_live;
    logic commit_hit;
    logic issue_live;

    assign commit_live = rdy && commit_valid && (commit_index != 5'd0);
    assign commit_hit  = busy_q[commit_index] &&
                         (tag_q[commit_index] == commit_rob_id);
    assign issue_live  = rdy && issue_valid && (issue_dest != 5'd0) && !flush;

    // Later non-blocking writes win: issue overrides the commit's busy
    // clear, and flush overrides everything on the busy vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            if (commit_live) begin
                value_q[commit_index] <= commit_value;
                if (commit_hit)
                    busy_q[commit_index] <= 1'b0;
            end
            if (issue_live) begin
                busy_q[issue_dest] <= 1'b1;
                tag_q[issue_dest]  <= issue_rob_id;
            end
            if (flush)
                busy_q <= '0;
        end
    end

    logic [4:0]         q_idx  [2];
    logic               q_busy [2];
    logic [ROB_LOG-1:0] q_id   [2];
    logic [31:0]        q_val  [2];

    assign q_idx[0] = rs1_index;
    assign q_idx[1] = rs2_index;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            q_busy[p] = 1'b0;
            q_id[p]   = '0;
            q_val[p]  = '0;
            if (q_idx[p] != 5'd0) begin
                if (busy_q[q_idx[p]] && rdy && commit_valid &&
                    commit_index == q_idx[p] &&
                    tag_q[q_idx[p]] == commit_rob_id) begin
                    q_val[p] = commit_value;
                end else if (busy_q[q_idx[p]]) begin
                    q_busy[p] = 1'b1;
                    q_id[p]   = tag_q[q_idx[p]];
                end else begin
                    q_val[p] = value_q[q_idx[p]];
                end
            end
        end
    end

    assign rs1_busy   = q_busy[0];
    assign rs1_rob_id = q_id[0];
    assign rs1_value  = q_val[0];
    assign rs2_busy   = q_busy[1];
    assign rs2_rob_id = q_id[1];
    assign rs2_value  = q_val[1];

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: array-based reference model checked
// every cycle, plus literal expectations at the scenario points.
module tb_rename_regfile;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        commit_valid, issue_valid;
    logic [4:0]  commit_index, issue_dest, rs1_index, rs2_index;
    logic [3:0]  commit_rob_id, issue_rob_id;
    logic [31:0] commit_value;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_rob_id, rs2_rob_id;
    logic [31:0] rs1_value, rs2_value;

    int checks = 0;
    int errors = 0;

    rename_regfile #(.ROB_LOG(4), .NREG(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .commit_valid(commit_valid), .commit_index(commit_index),
        .commit_rob_id(commit_rob_id), .commit_value(commit_value),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .issue_rob_id(issue_rob_id),
        .rs1_index(rs1_index), .rs2_index(rs2_index),
        .rs1_busy(rs1_busy), .rs1_rob_id(rs1_rob_id),
        .rs1_value(rs1_value),
        .rs2_busy(rs2_busy), .rs2_rob_id(rs2_rob_id),
        .rs2_value(rs2_value)
    );

    always #5 clk = ~clk;

    // Reference state: plain arrays updated from the architectural rules.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
        end else if (rdy) begin
            if (commit_valid && commit_index != 0) begin
                m_val[commit_index] = commit_value;
                if (m_busy[commit_index] && m_tag[commit_index] == commit_rob_id)
                    m_busy[commit_index] = 0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (issue_valid && issue_dest != 0) begin
                m_busy[issue_dest] = 1;
                m_tag[issue_dest]  = issue_rob_id;
            end
        end
    end

    function automatic logic [36:0] model_q(input logic [4:0] idx);
        if (idx == 0)
            return '0;
        if (m_busy[idx] && commit_valid && rdy &&
            commit_index == idx && m_tag[idx] == commit_rob_id)
            return {1'b0, 4'd0, commit_value};
        if (m_busy[idx])
            return {1'b1, m_tag[idx], 32'd0};
        return {1'b0, 4'd0, m_val[idx]};
    endfunction

    task automatic chk(input string name, input logic [36:0] act,
                       input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_rs1", {rs1_busy, rs1_rob_id, rs1_value}, model_q(rs1_index));
            chk("model_rs2", {rs2_busy, rs2_rob_id, rs2_value}, model_q(rs2_index));
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic settle;
        @(negedge clk); #1;
    endtask

    task automatic idle;
        flush = 0; commit_valid = 0; issue_valid = 0;
        commit_index = 0; commit_rob_id = 0; commit_value = 0;
        issue_dest = 0; issue_rob_id = 0;
    endtask

    task automatic lit1(input string n, input logic b, input logic [3:0] id,
                        input logic [31:0] v);
        chk(n, {rs1_busy, rs1_rob_id, rs1_value}, {b, id, v});
    endtask

    task automatic lit2(input string n, input logic b, input logic [3:0] id,
                        input logic [31:0] v);
        chk(n, {rs2_busy, rs2_rob_id, rs2_value}, {b, id, v});
    endtask

    task automatic issue(input logic [4:0] d, input logic [3:0] id);
        issue_valid = 1; issue_dest = d; issue_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] d, input logic [3:0] id,
                          input logic [31:0] v);
        commit_valid = 1; commit_index = d; commit_rob_id = id;
        commit_value = v;
    endtask

    initial begin
        rst = 1; rdy = 1; rs1_index = 0; rs2_index = 0;
        idle();
        tick(); tick();
        rst = 0;

        rs1_index = 5; rs2_index = 0;
        settle(); lit1("reset_x5", 0, 0, 0); lit2("reset_x0", 0, 0, 0);
        tick();

        issue(5, 3);
        settle(); lit1("issue_same_cycle", 0, 0, 0);
        tick(); idle();
        settle(); lit1("x5_busy", 1, 3, 0);
        tick();
        commit(5, 3, 32'hDEADBEEF);
        settle(); lit1("x5_bypass", 0, 0, 32'hDEADBEEF);
        tick(); idle();
        settle(); lit1("x5_stored", 0, 0, 32'hDEADBEEF);
        tick();

        issue(7, 2); tick();
        issue(7, 6); tick(); idle();
        rs1_index = 7;
        commit(7, 2, 11);
        settle(); lit1("x7_old_commit", 1, 6, 0);
        tick(); idle();
        settle(); lit1("x7_still_busy", 1, 6, 0);
        tick();
        commit(7, 6, 22);
        settle(); lit1("x7_bypass", 0, 0, 22);
        tick(); idle();
        settle(); lit1("x7_done", 0, 0, 22);
        tick();

        issue(9, 1); tick(); idle();
        rs1_index = 9; rs2_index = 9;
        issue(9, 4); commit(9, 1, 7);
        settle(); lit1("x9_rd_eq_rs1", 0, 0, 7);
        tick(); idle();
        settle(); lit2("x9_reissued", 1, 4, 0);
        tick();
        flush = 1;
        tick(); idle();
        settle(); lit1("x9_value_kept", 0, 0, 7);
        tick();

        for (int r = 1; r < 32; r++) begin
            issue(5'(r), 4'(r)); tick();
        end
        idle();
        rs1_index = 1; rs2_index = 2;
        flush = 1; commit(1, 1, 32'h100); issue(2, 9);
        settle(); lit1("flush_x1_bypass", 0, 0, 32'h100);
        lit2("flush_x2_query", 1, 2, 0);
        tick(); idle();
        settle(); lit1("flush_x1", 0, 0, 32'h100); lit2("flush_x2", 0, 0, 0);
        for (int r = 1; r < 32; r++) begin
            rs1_index = 5'(r); tick();
        end
        rs1_index = 5; rs2_index = 7;
        settle(); lit1("flush_x5", 0, 0, 32'hDEADBEEF);
        lit2("flush_x7", 0, 0, 22);
        tick();

        rs1_index = 0; rs2_index = 0;
        issue(0, 3); commit(0, 3, 99);
        settle(); lit1("x0_same", 0, 0, 0);
        tick(); idle();
        settle(); lit1("x0_after", 0, 0, 0); lit2("x0_after2", 0, 0, 0);
        tick();

        issue(3, 5); tick(); idle();
        rdy = 0; rs1_index = 3; rs2_index = 5;
        commit(3, 5, 1234); issue(5, 2);
        settle(); lit1("rdy0_no_bypass", 1, 5, 0);
        tick(); tick(); idle(); rdy = 1;
        settle(); lit1("rdy0_x3", 1, 5, 0);
        lit2("rdy0_x5", 0, 0, 32'hDEADBEEF);
        tick();

        rst = 1; commit(5, 0, 5);
        tick(); rst = 0; idle();
        settle(); lit1("rst_x3", 0, 0, 0); lit2("rst_x5", 0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
